saturn_nibble_alu: RTL and testbench
====================================

Name: saturn_nibble_alu

Overview:
Parametrised nibble-serial field ALU for the Saturn core: next generation of the single-register-copy ALU.
- Owns NREGS working registers of NIBBLES nibbles each.
- Executes one arithmetic/logic op over a field [start..last], one nibble per clock, with a carry chain, hex/BCD modes and start/busy/done handshake.
- Sits between the instruction decoder (issues ops) and the register dump/debug logic (read port).

Parameters:
NIBBLES, 16, nibbles per register; power of two, 2..16
FLD_W, 4, field index width = log2(NIBBLES)
NREGS, 4, number of working registers (A,B,C,D at default)
SEL_W, 2, register select width = log2(NREGS)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  op request, accepted only in IDLE
i_op  in  4  operation code
i_dest  in  SEL_W  destination register
i_src1  in  SEL_W  first source register
i_src2  in  SEL_W  second source register
i_src2_imm  in  1  1: second operand is i_imm (COPY also uses i_imm as source when set)
i_imm  in  4  immediate nibble, sampled at accept
i_field_start  in  FLD_W  first nibble index
i_field_last  in  FLD_W  last nibble index
i_dec  in  1  1 = BCD arithmetic, sampled at accept
o_busy  out  1  op in progress
o_done  out  1  one-cycle completion pulse
o_carry  out  1  carry/borrow flag
i_rd_sel  in  SEL_W  debug read select
o_rd_data  out  4*NIBBLES  combinational read of selected register

Behaviour:
- Reset (async, i_reset_n=0): all registers 0, o_carry 0, o_busy 0, o_done 0, FSM IDLE. Reset mid-op aborts; partial writes are lost because registers clear.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: i_start=1 latches op, selects, imm, field, dec; chain carry initialised (1 for INC/DEC, else 0); next state RUN.
- RUN: each cycle processes nibble idx (starts at i_field_start); writes dest nibble idx; idx <= (idx+1) mod NIBBLES.
  - Leaves after idx == last.
  - Nibble count = ((last - start) mod NIBBLES) + 1; start>last wraps through NIBBLES-1 to 0.
- DONE: o_done=1 for exactly this cycle; o_carry updated with final chain carry for arithmetic ops; next state IDLE.
- o_busy=1 in RUN and DONE.
- i_start while not IDLE is ignored (no queuing). Earliest re-accept: cycle after DONE.
- Latency from accept to o_done = nibble count + 1 cycles.
- Operands read from live register state at the nibble being processed. Each cycle writes only nibble idx, so dest==src is hazard-free.
- Ops (c = chain carry):
  - 0 ZERO: dest=0
  - 1 COPY: dest=src1 (or imm if i_src2_imm)
  - 2 EXCH: swap dest/src1 nibbles; dest==src1 leaves it unchanged
  - 3 ADD: dest=src1+src2+c
  - 4 SUB: dest=src1-src2-c
  - 5 INC: dest=src1+c
  - 6 DEC: dest=src1-c
  - 7 NEG: dest=0-src1-c
  - 8 AND: dest=src1&src2
  - 9 OR: dest=src1|src2
  - 10-15: no register write, FSM runs normally, carry unchanged.
- Hex arithmetic: 5-bit nibble sum; carry-out = bit 4. Borrow when difference < 0; result += 16.
- BCD arithmetic (i_dec=1): sum > 9 gives result sum-10 with carry 1. Difference < 0 gives result +10 with borrow 1. Non-BCD input nibbles give unspecified nibble values but must not hang the FSM.
- ZERO/COPY/EXCH/AND/OR/illegal leave o_carry unchanged.

Optional Feature:
SATURN_ALU_BCD_EN
- Defined: i_dec honoured as above.
- Undefined: BCD correction logic not built; i_dec ignored; all arithmetic hex.

Test Plan:
- Reset: pulse i_reset_n low mid-RUN of ZERO on a full-field op -> o_busy=0, o_done=0, all o_rd_data=0, o_carry=0 asynchronously; next i_start accepted normally.
- COPY imm 9, dest A, field 0..3 -> o_busy 5 cycles, o_done on cycle 5 after accept, A=0x...9999 (upper nibbles 0), o_carry unchanged.
- B=0x0001 (COPY imm 1, field 0..0).
  - ADD A=A+B, field 0..3, hex -> A low 16 bits 0x999A, o_carry 0.
  - Reset A to 0x9999, same op BCD -> 0x0000, o_carry 1 (undefined macro: 0x999A, carry 0).
- A=0, DEC dest A src1 A, field 0..1 -> A low byte 0xFF, o_carry 1. Then INC same field -> 0x00, o_carry 1.
- Wrap: COPY imm 7, dest C, start 15 last 0 -> C nibbles 15 and 0 = 7, others unchanged, 2 RUN cycles. i_start during RUN is ignored (no extra o_done).
- EXCH A/B field 0..1 with A=0x12, B=0x34 -> A=0x34, B=0x12. Op 12 on A -> A unchanged, o_done still pulses.

Source files
------------

// File: rtl/saturn_nibble_alu.sv
// saturn_nibble_alu: nibble-serial field ALU with NREGS working registers of
// NIBBLES nibbles. It runs one op over field [start..last], one nibble per clock.
// Ports: i_clk/i_reset_n (async low), i_start/i_op/i_dest/i_src1/i_src2,
//   i_src2_imm/i_imm, i_field_start/i_field_last and i_dec are the op request.
//   o_busy/o_done/o_carry give status. i_rd_sel/o_rd_data form the debug read port.
// Optional: define SATURN_ALU_BCD_EN to build BCD correction (i_dec honoured).
module saturn_nibble_alu #(
    parameter int NIBBLES = 16,
    parameter int FLD_W   = 4,
    parameter int NREGS   = 4,
    parameter int SEL_W   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [3:0]           i_op,
    input  logic [SEL_W-1:0]     i_dest,
    input  logic [SEL_W-1:0]     i_src1,
    input  logic [SEL_W-1:0]     i_src2,
    input  logic                 i_src2_imm,
    input  logic [3:0]           i_imm,
    input  logic [FLD_W-1:0]     i_field_start,
    input  logic [FLD_W-1:0]     i_field_last,
    input  logic                 i_dec,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_carry,
    input  logic [SEL_W-1:0]     i_rd_sel,
    output logic [4*NIBBLES-1:0] o_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ZERO = 4'd0;
    localparam logic [3:0] OP_COPY = 4'd1;
    localparam logic [3:0] OP_EXCH = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_DEC  = 4'd6;
    localparam logic [3:0] OP_NEG  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;

    state_t               state;
    logic [3:0]           op_q;
    logic [3:0]           imm_q;
    logic                 imm_sel_q;
    logic [SEL_W-1:0]     dest_q;
    logic [SEL_W-1:0]     src1_q;
    logic [SEL_W-1:0]     src2_q;
    logic [FLD_W-1:0]     idx;
    logic [FLD_W-1:0]     last_q;
    logic                 c_q;
    logic [4*NIBBLES-1:0] regs [NREGS];

`ifdef SATURN_ALU_BCD_EN
    logic                 dec_q;
`else
    logic                 unused_dec;
    assign unused_dec = i_dec;
`endif

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] nib_d;
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;
    logic [4:0] diff;
    logic [3:0] ar;
    logic       co;
    logic       sub;
    logic       arith;
    logic       wr;
    logic [3:0] res;

    assign o_rd_data = regs[i_rd_sel];

    // Operands come from live register state at the current nibble.
    assign nib_a = regs[src1_q][{idx, 2'b00} +: 4];
    assign nib_d = regs[dest_q][{idx, 2'b00} +: 4];
    assign nib_b = imm_sel_q ? imm_q : regs[src2_q][{idx, 2'b00} +: 4];

    always_comb begin
        x     = '0;
        y     = '0;
        sub   = 1'b0;
        arith = 1'b0;
        wr    = 1'b0;
        res   = '0;
        unique case (op_q)
            OP_ZERO: wr = 1'b1;
            OP_COPY: begin
                wr  = 1'b1;
                res = imm_sel_q ? imm_q : nib_a;
            end
            OP_EXCH: begin
                wr  = 1'b1;
                res = nib_a;
            end
            OP_ADD: begin
                arith = 1'b1;
                x     = nib_a;
                y     = nib_b;
            end
            OP_SUB: begin
                arith = 1'b1;
                sub   = 1'b1;
                x     = nib_a;
                y     = nib_b;
            end
            OP_INC: begin
                arith = 1'b1;
                x     = nib_a;
            end
            OP_DEC: begin
                arith = 1'b1;
                sub   = 1'b1;
                x     = nib_a;
            end
            OP_NEG: begin
                arith = 1'b1;
                sub   = 1'b1;
                y     = nib_a;
            end
            OP_AND: begin
                wr  = 1'b1;
                res = nib_a & nib_b;
            end
            OP_OR: begin
                wr  = 1'b1;
                res = nib_a | nib_b;
            end
            default: ;
        endcase

        sum  = {1'b0, x} + {1'b0, y} + {4'b0, c_q};
        // 5-bit two's complement: bit 4 is the borrow (range -16..15)
        diff = {1'b0, x} - {1'b0, y} - {4'b0, c_q};
        if (sub) begin
            co = diff[4];
            ar = diff[3:0];
`ifdef SATURN_ALU_BCD_EN
            if (dec_q && diff[4]) ar = diff[3:0] + 4'd10;
`endif
        end else begin
            co = sum[4];
            ar = sum[3:0];
`ifdef SATURN_ALU_BCD_EN
            if (dec_q) begin
                co = (sum > 5'd9);
                if (co) ar = sum[3:0] - 4'd10;
            end
`endif
        end

        if (arith) begin
            wr  = 1'b1;
            res = ar;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_carry   <= 1'b0;
            op_q      <= '0;
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
            dest_q    <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            idx       <= '0;
            last_q    <= '0;
            c_q       <= 1'b0;
`ifdef SATURN_ALU_BCD_EN
            dec_q     <= 1'b0;
`endif
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        op_q      <= i_op;
                        imm_q     <= i_imm;
                        imm_sel_q <= i_src2_imm;
                        dest_q    <= i_dest;
                        src1_q    <= i_src1;
                        src2_q    <= i_src2;
                        idx       <= i_field_start;
                        last_q    <= i_field_last;
                        c_q       <= (i_op == OP_INC) || (i_op == OP_DEC);
`ifdef SATURN_ALU_BCD_EN
                        dec_q     <= i_dec;
`endif
                        o_busy    <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (wr) regs[dest_q][{idx, 2'b00} +: 4] <= res;
                    // Second half of the swap; with dest==src1 both writes agree.
                    if (op_q == OP_EXCH) regs[src1_q][{idx, 2'b00} +: 4] <= nib_d;
                    if (arith) c_q <= co;
                    idx <= idx + 1'b1;
                    if (idx == last_q) begin
                        o_done <= 1'b1;
                        if (arith) o_carry <= co;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_saturn_nibble_alu.sv
// tb_saturn_nibble_alu: scoreboard bench for saturn_nibble_alu.
// A reference model predicts registers, carry and latency for each op.
module tb_saturn_nibble_alu;

`ifdef SATURN_ALU_BCD_EN
    localparam bit BCD_ON = 1'b1;
`else
    localparam bit BCD_ON = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [3:0]  i_op = '0;
    logic [1:0]  i_dest = '0;
    logic [1:0]  i_src1 = '0;
    logic [1:0]  i_src2 = '0;
    logic        i_src2_imm = 1'b0;
    logic [3:0]  i_imm = '0;
    logic [3:0]  i_field_start = '0;
    logic [3:0]  i_field_last = '0;
    logic        i_dec = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_carry;
    logic [1:0]  i_rd_sel = '0;
    logic [63:0] o_rd_data;

    saturn_nibble_alu dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_start(i_start),
        .i_op(i_op),
        .i_dest(i_dest),
        .i_src1(i_src1),
        .i_src2(i_src2),
        .i_src2_imm(i_src2_imm),
        .i_imm(i_imm),
        .i_field_start(i_field_start),
        .i_field_last(i_field_last),
        .i_dec(i_dec),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_carry(o_carry),
        .i_rd_sel(i_rd_sel),
        .o_rd_data(o_rd_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        int          lat;
        logic        c;
        int          sel0;
        int          sel1;
        logic [63:0] d0;
        logic [63:0] d1;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mregs[4];
    logic        mcarry;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_reg(input int s, output logic [63:0] v);
        i_rd_sel = s[1:0];
        #1;
        v = o_rd_data;
    endtask

    task automatic model_op(input int op, input int dest, input int src1,
                            input int src2, input bit ui, input int imm,
                            input int fs, input int fl, input bit dec,
                            output int n);
        int  i, a, b, d, r, c, s;
        bit  bcd;
        bcd = dec && BCD_ON;
        c = (op == 5 || op == 6) ? 1 : 0;
        n = (fl - fs + 16) % 16 + 1;
        i = fs;
        repeat (n) begin
            a = int'(mregs[src1][i*4 +: 4]);
            b = ui ? imm : int'(mregs[src2][i*4 +: 4]);
            d = int'(mregs[dest][i*4 +: 4]);
            r = -1;
            case (op)
                0: r = 0;
                1: r = ui ? imm : a;
                2: r = a;
                3, 5: begin
                    s = a + ((op == 3) ? b : 0) + c;
                    if (bcd) begin
                        if (s > 9) begin r = s - 10; c = 1; end
                        else begin r = s; c = 0; end
                    end else begin
                        r = s % 16;
                        c = s / 16;
                    end
                end
                4, 6, 7: begin
                    s = ((op == 7) ? 0 : a) - ((op == 4) ? b : (op == 7) ? a : 0) - c;
                    if (s < 0) begin r = s + (bcd ? 10 : 16); c = 1; end
                    else begin r = s; c = 0; end
                end
                8: r = a & b;
                9: r = a | b;
                default: r = -1;
            endcase
            if (r >= 0) mregs[dest][i*4 +: 4] = r[3:0];
            if (op == 2) mregs[src1][i*4 +: 4] = d[3:0];
            i = (i + 1) % 16;
        end
        if (op >= 3 && op <= 7) mcarry = c[0];
    endtask

    task automatic run_op(input string tag, input int op, input int dest,
                          input int src1, input int src2, input bit ui,
                          input int imm, input int fs, input int fl,
                          input bit dec, input bit poke);
        exp_t        e;
        int          n, lat, busy;
        bit          seen;
        logic [63:0] v;
        model_op(op, dest, src1, src2, ui, imm, fs, fl, dec, n);
        e.tag = tag;
        e.lat = n + 1;
        e.c = mcarry;
        e.sel0 = dest;
        e.sel1 = src1;
        e.d0 = mregs[dest];
        e.d1 = mregs[src1];
        q.push_back(e);

        @(negedge i_clk);
        i_op = op[3:0];
        i_dest = dest[1:0];
        i_src1 = src1[1:0];
        i_src2 = src2[1:0];
        i_src2_imm = ui;
        i_imm = imm[3:0];
        i_field_start = fs[3:0];
        i_field_last = fl[3:0];
        i_dec = dec;
        i_start = 1'b1;
        lat = 0;
        busy = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge i_clk);
            lat++;
            i_start = poke && (lat == 1);
            if (o_busy) busy++;
            if (o_done) seen = 1'b1;
        end

        e = q.pop_front();
        check({e.tag, "_done"}, 64'(seen), 64'd1);
        check({e.tag, "_lat"}, 64'(lat), 64'(e.lat));
        check({e.tag, "_busy"}, 64'(busy), 64'(e.lat));
        check({e.tag, "_carry"}, 64'(o_carry), 64'(e.c));
        read_reg(e.sel0, v);
        check({e.tag, "_dest"}, v, e.d0);
        read_reg(e.sel1, v);
        check({e.tag, "_src1"}, v, e.d1);

        @(negedge i_clk);
        check({e.tag, "_pulse"}, 64'(o_done), 64'd0);
        check({e.tag, "_idle"}, 64'(o_busy), 64'd0);
        if (poke) begin
            repeat (3) begin
                @(negedge i_clk);
                check({e.tag, "_noextra"}, 64'(o_done), 64'd0);
            end
        end
    endtask

    initial begin
        logic [63:0] v;
        for (int r = 0; r < 4; r++) mregs[r] = '0;
        mcarry = 1'b0;

        #1;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_carry", 64'(o_carry), 64'd0);
        read_reg(0, v);
        check("rst_a", v, 64'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        run_op("copy9", 1, 0, 0, 0, 1, 9, 0, 3, 0, 0);
        read_reg(0, v);
        check("copy9_k", v, 64'h9999);
        run_op("copyb", 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        run_op("addhex", 3, 0, 0, 1, 0, 0, 0, 3, 0, 0);
        read_reg(0, v);
        check("addhex_k", v, 64'h999A);
        check("addhex_c", 64'(o_carry), 64'd0);

        run_op("copy9b", 1, 0, 0, 0, 1, 9, 0, 3, 0, 0);
        run_op("addbcd", 3, 0, 0, 1, 0, 0, 0, 3, 1, 0);
        read_reg(0, v);
        check("addbcd_k", v, BCD_ON ? 64'h0000 : 64'h999A);
        check("addbcd_c", 64'(o_carry), BCD_ON ? 64'd1 : 64'd0);

        run_op("zeroa", 0, 0, 0, 0, 0, 0, 0, 15, 0, 0);
        run_op("dec", 6, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        read_reg(0, v);
        check("dec_k", v, 64'hFF);
        check("dec_c", 64'(o_carry), 64'd1);
        run_op("inc", 5, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        read_reg(0, v);
        check("inc_k", v, 64'h00);
        check("inc_c", 64'(o_carry), 64'd1);

        run_op("wrap", 1, 2, 0, 0, 1, 7, 15, 0, 0, 1);
        read_reg(2, v);
        check("wrap_k", v, 64'h7000_0000_0000_0007);

        run_op("za", 0, 0, 0, 0, 0, 0, 0, 15, 0, 0);
        run_op("a0", 1, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        run_op("a1", 1, 0, 0, 0, 1, 1, 1, 1, 0, 0);
        run_op("zb", 0, 1, 0, 0, 0, 0, 0, 15, 0, 0);
        run_op("b0", 1, 1, 0, 0, 1, 4, 0, 0, 0, 0);
        run_op("b1", 1, 1, 0, 0, 1, 3, 1, 1, 0, 0);
        run_op("exch", 2, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        read_reg(0, v);
        check("exch_a", v, 64'h34);
        read_reg(1, v);
        check("exch_b", v, 64'h12);
        run_op("ill12", 12, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        read_reg(0, v);
        check("ill12_k", v, 64'h34);

        run_op("subbcd", 4, 3, 1, 0, 0, 0, 0, 1, 1, 0);
        read_reg(3, v);
        check("subbcd_k", v, BCD_ON ? 64'h78 : 64'hDE);
        check("subbcd_c", 64'(o_carry), 64'd1);

        for (int k = 0; k < 20; k++) begin
            run_op("rnd", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0, 0);
        end

        run_op("zeroa2", 0, 0, 0, 0, 0, 0, 0, 15, 0, 0);
        run_op("dec1", 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        i_op = 4'd0;
        i_dest = 2'd0;
        i_field_start = 4'd0;
        i_field_last = 4'd15;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_done", 64'(o_done), 64'd0);
        check("arst_carry", 64'(o_carry), 64'd0);
        for (int r = 0; r < 4; r++) begin
            read_reg(r, v);
            check("arst_reg", v, 64'd0);
        end
        for (int r = 0; r < 4; r++) mregs[r] = '0;
        mcarry = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        run_op("post", 1, 3, 0, 0, 1, 5, 0, 0, 0, 0);
        read_reg(3, v);
        check("post_k", v, 64'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
